// File: rtl/mux_adder_pkg.sv
// Shared types and sizing helpers for the muxed digit-serial adder.
package mux_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-wide ripple adder; also exposes the carry into its top bit.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/mux_digit_serial_adder.sv
// Muxed operand selection, digit-serial add/subtract, result steered to one of two ports.
module mux_digit_serial_adder
  import mux_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic             sel_a,
  input  logic             sel_b,
  input  logic             sel_s,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum0,
  output logic [WIDTH-1:0] sum1,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NDIG = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW   = cnt_width(NDIG);

  if ((DIGIT == 0) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("mux_digit_serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             sel_s_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [DIGIT-1:0] d_s;
  logic             d_cout;
  logic             d_cmsb;
  logic [WIDTH-1:0] res_nxt;

  assign a_sel = sel_a ? a1 : a0;
  assign b_sel = sel_b ? b1 : b0;

  // New digit enters at the MSB end so the LSB digit lands at bit 0 after NDIG steps.
  assign res_nxt = (res >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .s        (d_s),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum0      <= '0;
      sum1      <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      sel_s_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a_sel;
            b_sh     <= sub ? ~b_sel : b_sel;
            carry    <= sub;
            sel_s_q  <= sel_s;
            res      <= '0;
            cnt      <= CW'(NDIG - 1);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= d_cout;
          res   <= res_nxt;
          if (cnt == '0) begin
            // Final digit: its top-bit carries give the MSB carry-in/out for ovf.
            sum0      <= sel_s_q ? '0 : res_nxt;
            sum1      <= sel_s_q ? res_nxt : '0;
            cout      <= d_cout;
            ovf       <= d_cmsb ^ d_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum0      <= '0;
            sum1      <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
